// File: rtl/adau_spi_pkg.sv
// adau_spi_pkg: shared state type and frame layout for the ADAU control-port SPI master.
package adau_spi_pkg;

  // One control-port frame: chip address/RW, register address, data byte
  localparam int FRAME_BITS    = 32;
  localparam int CHIP_ADDR_MSB = 31;
  localparam int CHIP_ADDR_LSB = 24;
  localparam int REG_ADDR_MSB  = 23;
  localparam int REG_ADDR_LSB  = 8;
  localparam int DATA_MSB      = 7;
  localparam int DATA_LSB      = 0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_e;

endpackage

// File: rtl/adau_spi_master_if.sv
// adau_spi_master_if: host handshake plus ADAU control-port pins.
// The master modport is the controller's view, the slave modport is the host/codec side.
interface adau_spi_master_if;
  import adau_spi_pkg::*;

  logic [FRAME_BITS-1:0] command;
  logic                  command_valid;
  logic                  spi_ready;
  logic                  spi_cs_n;
  logic                  spi_sclk;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic [7:0]            rdata;
  logic                  rdata_valid;

  modport master (
    input  command, command_valid, spi_miso,
    output spi_ready, spi_cs_n, spi_sclk, spi_mosi, rdata, rdata_valid
  );

  modport slave (
    output command, command_valid, spi_miso,
    input  spi_ready, spi_cs_n, spi_sclk, spi_mosi, rdata, rdata_valid
  );

endinterface

// File: rtl/adau_spi_tick.sv
// adau_spi_tick: pulses once every CLK_DIV system clocks to pace SCLK half-periods.
// The count restarts when a frame is accepted so every frame has identical timing.
module adau_spi_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;

  assign tick = (div_cnt == LAST);

  // Count system clocks within one half-period, wrapping on the tick or a restart
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (restart || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/adau_spi_master.sv
// adau_spi_master: sends 32-bit ADAU control-port frames MSB first over CLATCH/CCLK/CDATA.
// Optional feature: define ADAU_SPI_READBACK_EN to capture COUT and report the last data byte.
module adau_spi_master
  import adau_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input logic               clk,
  input logic               reset_n,
  adau_spi_master_if.master bus
);

  localparam logic [5:0] BIT_LAST = 6'(FRAME_BITS - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  spi_state_e             state;
  logic [5:0]             bit_cnt;
  logic [7:0]             gap_cnt;
  logic [FRAME_BITS-2:0]  tx_sr;
  logic                   cs_n_q;
  logic                   sclk_q;
  logic                   mosi_q;
  logic                   tick;
  logic                   accept;

  assign accept        = (state == IDLE) && bus.command_valid;
  assign bus.spi_ready = (state == IDLE);
  assign bus.spi_cs_n  = cs_n_q;
  assign bus.spi_sclk  = sclk_q;
  assign bus.spi_mosi  = mosi_q;

  adau_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (accept),
    .tick    (tick)
  );

  // Frame sequencer: latch command, shift 32 bits, hold CLATCH, then enforce the CS gap
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      tx_sr   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.command_valid) begin
            state   <= SETUP;
            cs_n_q  <= 1'b0;
            mosi_q  <= bus.command[FRAME_BITS-1];
            tx_sr   <= bus.command[FRAME_BITS-2:0];
            bit_cnt <= '0;
          end
        end
        SETUP: begin
          if (tick) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              mosi_q <= tx_sr[FRAME_BITS-2];
              tx_sr  <= {tx_sr[FRAME_BITS-3:0], 1'b0};
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                state   <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state   <= GAP;
            cs_n_q  <= 1'b1;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ADAU_SPI_READBACK_EN
  logic [FRAME_BITS-1:0] rx_sr;
  logic [7:0]            rdata_q;
  logic                  rdata_valid_q;

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;

  // Sample COUT as SCLK rises and publish the data byte when the frame closes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_sr         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      if (state == SHIFT && tick && !sclk_q) begin
        rx_sr <= {rx_sr[FRAME_BITS-2:0], bus.spi_miso};
      end
      if (state == HOLD && tick) begin
        rdata_q       <= rx_sr[DATA_MSB:DATA_LSB];
        rdata_valid_q <= 1'b1;
      end
    end
  end
`else
  logic unused_miso;

  assign unused_miso     = bus.spi_miso;
  assign bus.rdata       = '0;
  assign bus.rdata_valid = 1'b0;
`endif

endmodule

// File: tb/tb_adau_spi_master.sv
// tb_adau_spi_master: directed checks of frame timing, bit order, back-to-back frames,
// readback (when ADAU_SPI_READBACK_EN is defined), mid-frame reset and CLK_DIV=1.
module tb_adau_spi_master;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Results of the most recent frame on the CLK_DIV=4 instance
  int          f_busy;
  int          f_rises;
  int          f_cs_high;
  int          f_rv;
  int          f_rv_at;
  logic [31:0] f_mosi;
  logic [7:0]  f_rdata;

  adau_spi_master_if bus4 ();
  adau_spi_master_if bus1 ();

  adau_spi_master #(.CLK_DIV(4), .CS_GAP(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus4.master)
  );

  adau_spi_master #(.CLK_DIV(1), .CS_GAP(3)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1.master)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Send one frame on the CLK_DIV=4 instance while acting as the codec on COUT
  task automatic run_frame4(input logic [31:0] cmd, input logic [31:0] next_cmd,
                            input logic keep_valid, input logic [31:0] miso_word);
    int   idx;
    logic prev_sclk;
    logic prev_cs;
    logic seen_low;
    idx       = 31;
    prev_sclk = 1'b0;
    prev_cs   = 1'b1;
    seen_low  = 1'b0;
    f_busy    = 0;
    f_rises   = 0;
    f_cs_high = 0;
    f_rv      = 0;
    f_rv_at   = 0;
    f_mosi    = '0;
    f_rdata   = '0;
    bus4.command       = cmd;
    bus4.command_valid = 1'b1;
    @(posedge clk); #1;
    bus4.command       = next_cmd;
    bus4.command_valid = keep_valid;
    while (bus4.spi_ready === 1'b0 && f_busy < 2000) begin
      f_busy++;
      if (prev_cs && !bus4.spi_cs_n) begin
        idx           = 31;
        bus4.spi_miso = miso_word[idx];
        seen_low      = 1'b1;
      end
      if (!prev_sclk && bus4.spi_sclk) begin
        f_rises++;
        f_mosi = {f_mosi[30:0], bus4.spi_mosi};
      end
      if (prev_sclk && !bus4.spi_sclk && idx > 0) begin
        idx--;
        bus4.spi_miso = miso_word[idx];
      end
      if (seen_low && bus4.spi_cs_n) f_cs_high++;
      if (bus4.rdata_valid) begin
        f_rv++;
        f_rdata = bus4.rdata;
        f_rv_at = f_busy;
      end
      prev_sclk = bus4.spi_sclk;
      prev_cs   = bus4.spi_cs_n;
      @(posedge clk); #1;
    end
    bus4.spi_miso = 1'b0;
    checks++;
    if (f_busy >= 2000) begin
      errors++;
      $display("[TB] FAIL frame_timeout: busy %0d cycles, required ready within 2000", f_busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus4.spi_cs_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_cs_n: got %b, expected 1", bus4.spi_cs_n);
    end
    checks++;
    if (bus4.spi_sclk !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_sclk: got %b, expected 0", bus4.spi_sclk);
    end
    checks++;
    if (bus4.spi_mosi !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mosi: got %b, expected 0", bus4.spi_mosi);
    end
    checks++;
    if (bus4.rdata !== 8'h00 || bus4.rdata_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: got %h/%b, expected 00/0", bus4.rdata, bus4.rdata_valid);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus4.spi_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset: got %b, expected 1", bus4.spi_ready);
    end
  endtask

  task automatic test_idle_static();
    bus4.command_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus4.command = 32'hC3A5_0F00 ^ (32'(i) * 32'h0101_0101);
      @(posedge clk); #1;
      checks++;
      if ({bus4.spi_ready, bus4.spi_cs_n, bus4.spi_sclk, bus4.spi_mosi, bus4.rdata_valid} !== 5'b11000) begin
        errors++;
        $display("[TB] FAIL idle_static[%0d]: got %b, expected 11000", i,
                 {bus4.spi_ready, bus4.spi_cs_n, bus4.spi_sclk, bus4.spi_mosi, bus4.rdata_valid});
      end
    end
  endtask

  task automatic test_single_frame();
    run_frame4(32'h0040_0001, 32'hDEAD_BEEF, 1'b0, 32'h0);
    checks++;
    if (f_rises !== 32) begin
      errors++;
      $display("[TB] FAIL single_sclk_rises: got %0d, expected 32", f_rises);
    end
    checks++;
    if (f_mosi !== 32'h0040_0001) begin
      errors++;
      $display("[TB] FAIL single_mosi: got %h, expected 00400001", f_mosi);
    end
    checks++;
    if (f_busy !== 272) begin
      errors++;
      $display("[TB] FAIL single_busy: got %0d, expected 272", f_busy);
    end
    checks++;
    if (f_cs_high !== 8) begin
      errors++;
      $display("[TB] FAIL single_cs_gap: got %0d, expected 8", f_cs_high);
    end
  endtask

  task automatic test_readback();
    run_frame4(32'h0140_1500, 32'h0, 1'b0, 32'h0000_00A5);
    checks++;
    if (f_busy !== 272) begin
      errors++;
      $display("[TB] FAIL readback_busy: got %0d, expected 272", f_busy);
    end
`ifdef ADAU_SPI_READBACK_EN
    checks++;
    if (f_rv !== 1) begin
      errors++;
      $display("[TB] FAIL readback_valid_count: got %0d, expected 1", f_rv);
    end
    checks++;
    if (f_rdata !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL readback_rdata: got %h, expected a5", f_rdata);
    end
    checks++;
    if (f_rv_at !== 265) begin
      errors++;
      $display("[TB] FAIL readback_valid_cycle: got %0d, expected 265", f_rv_at);
    end
`else
    checks++;
    if (f_rv !== 0) begin
      errors++;
      $display("[TB] FAIL readback_valid_count: got %0d, expected 0", f_rv);
    end
    checks++;
    if (bus4.rdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL readback_rdata: got %h, expected 00", bus4.rdata);
    end
`endif
  endtask

  // A busy count of 272 on the next frame proves it was accepted on the first IDLE edge,
  // so the CLATCH-high stretch between frames is the CS_GAP cycles plus that acceptance cycle
  task automatic test_back_to_back();
    logic [31:0] cmds [3];
    logic [31:0] nexts [3];
    logic        keeps [3];
    cmds  = '{32'h0000_0000, 32'h0000_0000, 32'h0040_1500};
    nexts = '{32'h0000_0000, 32'h0040_1500, 32'hFFFF_FFFF};
    keeps = '{1'b1, 1'b1, 1'b0};
    for (int f = 0; f < 3; f++) begin
      run_frame4(cmds[f], nexts[f], keeps[f], 32'h0);
      checks++;
      if (f_busy !== 272) begin
        errors++;
        $display("[TB] FAIL b2b_busy[%0d]: got %0d, expected 272", f, f_busy);
      end
      checks++;
      if (f_mosi !== cmds[f]) begin
        errors++;
        $display("[TB] FAIL b2b_mosi[%0d]: got %h, expected %h", f, f_mosi, cmds[f]);
      end
      checks++;
      if (f_cs_high !== 8) begin
        errors++;
        $display("[TB] FAIL b2b_cs_gap[%0d]: got %0d, expected 8", f, f_cs_high);
      end
    end
  endtask

  task automatic test_reset_abort();
    int   rises;
    int   cyc;
    logic prev_sclk;
    logic bad;
    rises     = 0;
    cyc       = 0;
    prev_sclk = 1'b0;
    bus4.command       = 32'h1234_5678;
    bus4.command_valid = 1'b1;
    @(posedge clk); #1;
    bus4.command_valid = 1'b0;
    while (rises < 20 && cyc < 1000) begin
      if (!prev_sclk && bus4.spi_sclk) rises++;
      prev_sclk = bus4.spi_sclk;
      if (rises < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    checks++;
    if (rises !== 20) begin
      errors++;
      $display("[TB] FAIL abort_progress: got %0d rises, expected 20", rises);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus4.spi_cs_n !== 1'b1 || bus4.spi_sclk !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_pins: got cs_n=%b sclk=%b, expected cs_n=1 sclk=0",
               bus4.spi_cs_n, bus4.spi_sclk);
    end
    bad = bus4.rdata_valid;
    @(posedge clk); #1;
    bad = bad | bus4.rdata_valid;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus4.spi_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_ready: got %b, expected 1", bus4.spi_ready);
    end
    for (int i = 0; i < 300; i++) begin
      bad = bad | bus4.rdata_valid | ~bus4.spi_cs_n;
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_quiet: got activity=%b, expected 0", bad);
    end
  endtask

  task automatic test_clk_div1();
    int          busy;
    int          rises;
    int          toggles;
    int          first_t;
    int          last_t;
    logic        prev_sclk;
    logic [31:0] mosi_w;
    busy = 0; rises = 0; toggles = 0; first_t = 0; last_t = 0;
    prev_sclk = 1'b0;
    mosi_w    = '0;
    bus1.command       = 32'hFFFF_FFFF;
    bus1.command_valid = 1'b1;
    @(posedge clk); #1;
    bus1.command_valid = 1'b0;
    bus1.command       = 32'h0;
    while (bus1.spi_ready === 1'b0 && busy < 500) begin
      busy++;
      if (bus1.spi_sclk !== prev_sclk) begin
        toggles++;
        if (first_t == 0) first_t = busy;
        last_t = busy;
        if (bus1.spi_sclk) begin
          rises++;
          mosi_w = {mosi_w[30:0], bus1.spi_mosi};
        end
      end
      prev_sclk = bus1.spi_sclk;
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 69) begin
      errors++;
      $display("[TB] FAIL div1_busy: got %0d, expected 69", busy);
    end
    checks++;
    if (rises !== 32 || mosi_w !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL div1_mosi: got %0d rises mosi %h, expected 32 rises ffffffff", rises, mosi_w);
    end
    checks++;
    if (toggles !== 64 || (last_t - first_t) !== 63) begin
      errors++;
      $display("[TB] FAIL div1_sclk_toggle: got %0d toggles span %0d, expected 64 span 63",
               toggles, last_t - first_t);
    end
  endtask

  // Bound the whole run in case the design never returns to idle
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Run the scenarios in sequence and report
  initial begin
    bus4.command = '0; bus4.command_valid = 1'b0; bus4.spi_miso = 1'b0;
    bus1.command = '0; bus1.command_valid = 1'b0; bus1.spi_miso = 1'b0;
    test_reset();
    test_idle_static();
    test_single_frame();
    test_readback();
    test_back_to_back();
    test_reset_abort();
    test_clk_div1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adau_spi_master.md
ADAU_SPI_MASTER -- requirements
Module: adau_spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, system clocks per SCLK half-period; legal range 1..255.
REQ-002 Parameter CS_GAP, default 8, system clocks with CS_N high between frames; legal range 1..255.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 command  input  32  frame to send: [31:24] chip address/RW, [23:8] register address, [7:0] data.
REQ-006 command_valid  input  1  command holds a frame to send.
REQ-007 spi_ready  output  1  high when idle and able to accept a frame.
REQ-008 spi_cs_n  output  1  ADAU CLATCH, active low.
REQ-009 spi_sclk  output  1  ADAU CCLK, idle low.
REQ-010 spi_mosi  output  1  ADAU CDATA.
REQ-011 spi_miso  input  1  ADAU COUT.
REQ-012 rdata  output  8  last received data byte.
REQ-013 rdata_valid  output  1  one-cycle pulse when rdata updates.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-015 spi_ready SHALL be high only in IDLE, decoded from registered state, with no combinational path from command_valid.
REQ-016 A frame is accepted on the edge where spi_ready and command_valid are both high; command is latched on that edge; upstream may change command on the following cycle.
REQ-017 On acceptance: IDLE->SETUP; spi_cs_n low and spi_mosi=command[31] from the next cycle; SETUP lasts CLK_DIV cycles with spi_sclk low.
REQ-018 SHIFT sends 32 bits MSB first; each bit has CLK_DIV cycles sclk low then CLK_DIV cycles sclk high; spi_mosi changes only at sclk falling transitions.
REQ-019 spi_miso SHALL be sampled on the system edge where spi_sclk goes high; 32 samples form a shift register.
REQ-020 After the high phase of bit 0: HOLD for CLK_DIV cycles (sclk low, cs_n low), then GAP for CS_GAP cycles with cs_n high, then IDLE.
REQ-021 Busy time from acceptance edge to spi_ready high SHALL be exactly (66*CLK_DIV + CS_GAP) cycles.
REQ-022 command_valid low while in IDLE SHALL leave all outputs static.
REQ-023 command_valid changes while busy SHALL be ignored; back-to-back frames are accepted on the first IDLE cycle.
REQ-024 The bit counter SHALL be 6 bits and the divider counter 8 bits; no wrap beyond 32 bits or CLK_DIV.

Reset
REQ-025 With reset_n low on an edge: state IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, rdata=0, rdata_valid=0, counters=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; cs_n goes high on the same edge; no rdata_valid pulse.
REQ-027 spi_ready SHALL be high on the first cycle after reset_n deasserts.

Configuration
REQ-028 With macro ADAU_SPI_READBACK_EN defined: on entry to GAP, rdata gets the received shift register bits [7:0] and rdata_valid pulses for one cycle.
REQ-029 Without ADAU_SPI_READBACK_EN: no receive shift register; rdata tied 0; rdata_valid tied 0; spi_miso unused; port list unchanged.

Structure
REQ-030 Package adau_spi_pkg SHALL hold the state enum, FRAME_BITS=32 and the field positions of the chip address, register address and data bytes.
REQ-031 Sub-module adau_spi_tick generates the CLK_DIV half-period tick; it restarts on frame acceptance.

Verification
REQ-032 CLK_DIV=4, CS_GAP=8, send 32'h00_4000_01 -> 32 sclk rising edges, sampled mosi equals 0x00400001, spi_ready low for 272 cycles.
REQ-033 Three frames with command_valid held high (0x00000000, 0x00000000, 0x004015_00) -> each accepted on the first IDLE cycle, with exactly CS_GAP cycles of cs_n high between frames.
REQ-034 Readback enabled, miso model drives 0xA5 during bits 7..0 -> rdata=8'hA5 and rdata_valid high for exactly 1 cycle on GAP entry.
REQ-035 reset_n pulled low after bit 12 of a frame -> cs_n=1 and sclk=0 on the next edge, no rdata_valid, spi_ready=1 once reset_n is released.
REQ-036 CLK_DIV=1 with frame 0xFFFFFFFF -> sclk toggles every cycle, mosi constant 1, busy time 66+CS_GAP cycles.
